serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b - bin` over WIDTH clock cycles, LSB first, using a single borrow flip-flop. It is the inverse-operation companion to the team's combinational ripple-carry adder datapath. It trades area for latency, and sits behind a simple start/done handshake so a controller can issue subtractions back to back.

## Interface
Parameters:
- `WIDTH`, default 4: operand and result width in bits; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: request a subtraction; sampled only in IDLE.
- `a` in WIDTH: minuend; captured on the accepted `start` edge.
- `b` in WIDTH: subtrahend; captured on the accepted `start` edge.
- `bin` in 1: borrow-in; captured on the accepted `start` edge.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; `diff`/`bout`/`ovf` are valid from this cycle on.
- `diff` out WIDTH: result, modulo 2^WIDTH.
- `bout` out 1: borrow-out; 1 iff a < b + bin (unsigned).
- `ovf` out 1: signed overflow flag (see Configuration).

## Operation
State machine has three states: IDLE, RUN and DONE.
- **IDLE → RUN:** on an edge with `start`=1.
  - Load shift registers `sa` = a and `sb` = b.
  - Load the borrow FF with `bin`.
  - Clear the bit counter `cnt` to 0.
  - Latch `a[WIDTH-1]` and `b[WIDTH-1]` for overflow detection.
- **RUN, each edge:**
  - `d = sa[0] ^ sb[0] ^ borrow`.
  - `borrow' = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow)`.
  - Shift the result register right with `d` entering the MSB.
  - Shift `sa` and `sb` right by one.
  - `cnt` increments.
  - When `cnt` = WIDTH-1 on the edge, go to DONE.
- **DONE → IDLE:** unconditionally on the next edge.
- **Outputs:**
  - `diff` and `bout` are driven from the result register and borrow FF, and update only at the RUN→DONE transition.
  - They hold their values through DONE and IDLE until the next completed operation.
  - Intermediate shift contents are never visible on `diff`.
- **`start` ignored:** `start` is ignored in RUN and DONE, with no queuing and no effect on the current operation.
- **Operand changes:** changes on `a`, `b` or `bin` after the accepting edge have no effect.
- **`cnt` width:** `cnt` is `$clog2(WIDTH)` bits and never wraps in normal operation.

## Timing
- **Reset values:** `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0, state IDLE, `cnt`=0.
- **Latency:** `start` is accepted at edge E0, and bits 0..WIDTH-1 are computed at edges E1..EW.
  - `done`=1 and the results are valid in the cycle after EW.
  - `done` returns to 0 after E(W+1).
- **Throughput:** one operation per WIDTH+2 cycles.
  - `start` held continuously is re-accepted at the first edge seen in IDLE.
- **`busy`:** high from the cycle after E0 through the DONE cycle inclusive.
- **Reset mid-operation:** `rst_n`=0 at any edge in RUN or DONE aborts the operation.
  - All outputs go to their reset values on that edge.
  - No `done` pulse is issued.
- **`rst_n` and `start` at the same edge:** reset wins.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` is registered at the RUN→DONE transition as `(a_msb ≠ b_msb) & (diff_msb ≠ a_msb)`.
  - `a_msb`/`b_msb` are the values latched at start; `diff_msb` is the final result MSB.
  - It holds like `diff`.
- `SERIAL_SUB_OVF_EN` undefined:
  - No MSB latches and no overflow logic are built.
  - `ovf` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset and idle:** hold `rst_n`=0 for 2 cycles, then release with `start`=0 for 10 cycles → all outputs stay 0 and `busy`=0 throughout.
- **Basic unsigned subtractions (WIDTH=4):**
  - a=9, b=5, bin=0 → `done` in the 5th cycle after the accepting edge; `diff`=4, `bout`=0, `ovf`=0.
  - a=3, b=5, bin=0 → `diff`=0xE, `bout`=1.
  - a=0, b=0, bin=1 → `diff`=0xF, `bout`=1.
- **Signed overflow (macro defined):** a=7, b=8 → `diff`=0xF, `bout`=1, `ovf`=1.
  - Without the macro, the same stimulus gives `ovf`=0.
- **Back-to-back operation:**
  - Hold `start`=1 with a=9, b=5, then switch to a=2, b=1 on the cycle `done` pulses → second result `diff`=1.
  - Exactly one `done` pulse per operation.
  - `start` pulsed during RUN is ignored.
- **Reset mid-RUN:** after 2 RUN edges of a=9, b=5, assert `rst_n`=0 → next cycle all outputs are 0 and no `done` pulse occurs.
  - A new start with a=1, b=1 then gives `diff`=0, `bout`=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first, one borrow FF.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg, res_reg, diff_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             borrow_reg, bout_reg;
    logic             d_bit, borrow_next, last_bit;

    // One full-subtractor cell applied to the current LSBs.
    assign d_bit       = sa_reg[0] ^ sb_reg[0] ^ borrow_reg;
    assign borrow_next = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & borrow_reg);
    assign last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sa_reg     <= '0;
            sb_reg     <= '0;
            res_reg    <= '0;
            diff_reg   <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg     <= a;
                        sb_reg     <= b;
                        borrow_reg <= bin;
                        cnt_reg    <= '0;
                    end
                end
                RUN: begin
                    sa_reg     <= sa_reg >> 1;
                    sb_reg     <= sb_reg >> 1;
                    borrow_reg <= borrow_next;
                    res_reg    <= {d_bit, res_reg[WIDTH-1:1]};
                    // Outputs only change once the whole word is assembled.
                    if (last_bit) begin
                        diff_reg <= {d_bit, res_reg[WIDTH-1:1]};
                        bout_reg <= borrow_next;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg, b_msb_reg, ovf_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                a_msb_reg <= a[WIDTH-1];
                b_msb_reg <= b[WIDTH-1];
            end
            // The last computed bit is the result MSB.
            if (state_reg == RUN && last_bit)
                ovf_reg <= (a_msb_reg != b_msb_reg) & (d_bit != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): reset, basic vectors, overflow, back-to-back, mid-run reset.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n, start, bin;
    logic [3:0] a, b;
    logic       busy, done, bout, ovf;
    logic [3:0] diff;

    int total = 0;
    int bad   = 0;
    logic [3:0] prev_diff = 4'h0;

`ifdef SERIAL_SUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation; optionally pulses start with other operands mid-run.
    task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                          input logic vbin, input logic [3:0] ed, input logic eb,
                          input logic eo, input bit glitch);
        int n;
        @(negedge clk);
        start = 1'b1; a = va; b = vb; bin = vbin;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; bin = ~vbin;
        check_val({tag, ".busy"}, busy, 1);
        n = 1;
        while (!done && n < 20) begin
            check_val({tag, ".hold"}, diff, prev_diff);
            if (glitch && n == 2) begin start = 1'b1; a = 4'hF; b = 4'h0; end
            if (glitch && n == 3) start = 1'b0;
            @(negedge clk);
            n++;
        end
        check_val({tag, ".lat"}, n, 5);
        check_val({tag, ".diff"}, diff, ed);
        check_val({tag, ".bout"}, bout, eb);
        check_val({tag, ".ovf"}, ovf, eo);
        check_val({tag, ".busy_done"}, busy, 1);
        @(negedge clk);
        check_val({tag, ".idle"}, {busy, done}, 2'b00);
        check_val({tag, ".keep"}, diff, ed);
        $display("op %s: a=%0h b=%0h bin=%0b -> diff=%0h bout=%0b ovf=%0b", tag, va, vb, vbin, diff, bout, ovf);
        prev_diff = ed;
    endtask

    initial begin
        int dones, first_at, second_at;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("reset_idle", {busy, done, diff, bout, ovf}, 8'h00);
        end
        $display("op reset: outputs idle for 10 cycles");

        run_op("sub9_5",   4'h9, 4'h5, 1'b0, 4'h4, 1'b0, 1'b0,   1'b0);
        run_op("sub3_5",   4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0,   1'b0);
        run_op("sub0_0_1", 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0,   1'b0);
        run_op("sub7_8",   4'h7, 4'h8, 1'b0, 4'hF, 1'b1, OVF_ON, 1'b0);
        run_op("sub8_1",   4'h8, 4'h1, 1'b0, 4'h7, 1'b0, OVF_ON, 1'b0);
        run_op("subF_F_1", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0,   1'b1);
        run_op("sub5_3_1", 4'h5, 4'h3, 1'b1, 4'h1, 1'b0, 1'b0,   1'b1);

        // Back-to-back with start held high.
        dones = 0; first_at = 0; second_at = 0;
        @(negedge clk);
        start = 1'b1; a = 4'h9; b = 4'h5; bin = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_at = i;
                    check_val("b2b.first", diff, 4'h4);
                    a = 4'h2; b = 4'h1;
                end else if (dones == 2) begin
                    second_at = i;
                    check_val("b2b.second", diff, 4'h1);
                    check_val("b2b.second_bout", bout, 1'b0);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_val("b2b.first_at", first_at, 5);
        check_val("b2b.gap", second_at - first_at, 6);
        check_val("b2b.pulses", dones, 2);
        $display("op b2b: dones=%0d first=%0d second=%0d", dones, first_at, second_at);

        // Reset after two RUN edges.
        @(negedge clk);
        start = 1'b1; a = 4'h9; b = 4'h5; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst.outs", {busy, done, diff, bout, ovf}, 8'h00);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("midrst.no_done", dones, 0);
        $display("op midrst: outputs cleared, dones=%0d", dones);
        prev_diff = 4'h0;
        run_op("sub1_1", 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
